// File: rtl/piece_queue_if.sv
// Piece hand-off bundle between the randomizer/game control side (master)
// and the piece queue (slave).
interface piece_queue_if;
    logic [2:0] random;
    logic       req;
    logic [2:0] piece;
    logic [2:0] next_piece;
    logic       valid;

    modport master (
        output random,
        output req,
        input  piece,
        input  next_piece,
        input  valid
    );

    modport slave (
        input  random,
        input  req,
        output piece,
        output next_piece,
        output valid
    );
endinterface

// File: rtl/piece_queue.sv
// Current + preview piece holder fed by the free-running 1..7 randomizer.
// Define PIECE_QUEUE_BAG7_EN to deal pieces by the 7-bag rule (no repeat within a bag).
module piece_queue (
    input  logic         clk,
    input  logic         rst,
    piece_queue_if.slave bus
);

`ifdef PIECE_QUEUE_BAG7_EN
    typedef enum logic [1:0] {IDLE, SAMPLE, SCAN} state_t;
`else
    typedef enum logic [1:0] {IDLE, SAMPLE} state_t;
`endif

    state_t     state, state_d;
    logic [2:0] piece_q, piece_d;
    logic [2:0] next_q, next_d;
    logic       cur_full, cur_full_d;
    logic       nxt_full, nxt_full_d;
    logic       valid_q, valid_d;
    logic       accept;
    logic       commit;
    logic [2:0] commit_val;
    logic [2:0] sampled;

`ifdef PIECE_QUEUE_BAG7_EN
    logic [6:0] used, used_d, used_set;
    logic [2:0] cand, cand_d;

    function automatic logic [6:0] code_bit(input logic [2:0] code);
        code_bit = 7'd1 << (code - 3'd1);
    endfunction

    function automatic logic [2:0] wrap_inc(input logic [2:0] code);
        wrap_inc = (code == 3'd7) ? 3'd1 : code + 3'd1;
    endfunction
`endif

    assign sampled = (bus.random == 3'd0) ? 3'd1 : bus.random;

    always_comb begin
        state_d    = state;
        piece_d    = piece_q;
        next_d     = next_q;
        cur_full_d = cur_full;
        nxt_full_d = nxt_full;
        accept     = 1'b0;
        commit     = 1'b0;
        commit_val = sampled;
`ifdef PIECE_QUEUE_BAG7_EN
        used_d     = used;
        used_set   = used;
        cand_d     = cand;
`endif
        case (state)
            IDLE: begin
                if (!cur_full || !nxt_full) begin
                    state_d = SAMPLE;
                end else if (valid_q && bus.req) begin
                    accept     = 1'b1;
                    piece_d    = next_q;
                    nxt_full_d = 1'b0;
                    state_d    = SAMPLE;
                end
            end
            SAMPLE: begin
`ifdef PIECE_QUEUE_BAG7_EN
                cand_d = sampled;
                if ((used & code_bit(sampled)) == '0) begin
                    commit = 1'b1;
                end else begin
                    cand_d  = wrap_inc(sampled);
                    state_d = SCAN;
                end
`else
                commit = 1'b1;
`endif
            end
`ifdef PIECE_QUEUE_BAG7_EN
            SCAN: begin
                commit_val = cand;
                if ((used & code_bit(cand)) == '0) begin
                    commit = 1'b1;
                end else begin
                    cand_d = wrap_inc(cand);
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // The current slot is always filled before the preview slot.
        if (commit) begin
            state_d = IDLE;
            if (!cur_full) begin
                piece_d    = commit_val;
                cur_full_d = 1'b1;
            end else begin
                next_d     = commit_val;
                nxt_full_d = 1'b1;
            end
`ifdef PIECE_QUEUE_BAG7_EN
            used_set = used | code_bit(commit_val);
            used_d   = (used_set == 7'h7F) ? '0 : used_set;
`endif
        end

        valid_d = (state == IDLE) && cur_full && nxt_full && !accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            piece_q  <= '0;
            next_q   <= '0;
            cur_full <= 1'b0;
            nxt_full <= 1'b0;
            valid_q  <= 1'b0;
`ifdef PIECE_QUEUE_BAG7_EN
            used     <= '0;
            cand     <= '0;
`endif
        end else begin
            state    <= state_d;
            piece_q  <= piece_d;
            next_q   <= next_d;
            cur_full <= cur_full_d;
            nxt_full <= nxt_full_d;
            valid_q  <= valid_d;
`ifdef PIECE_QUEUE_BAG7_EN
            used     <= used_d;
            cand     <= cand_d;
`endif
        end
    end

    assign bus.piece      = piece_q;
    assign bus.next_piece = next_q;
    assign bus.valid      = valid_q;

endmodule
